// File: rtl/icb_dcache_router.sv
// icb_dcache_router: splits LSU ICB traffic between the dcache (m0, cacheable)
// and the peripheral bus (m1, uncacheable window). A small in-order tracking
// FIFO remembers the target of every outstanding command so responses are
// returned to the LSU strictly in issue order.
module icb_dcache_router #(
  parameter logic [31:0] UNCACHEABLE_BASE = 32'h4000_0000,
  parameter logic [31:0] UNCACHEABLE_LEN  = 32'h1000_0000,
  parameter int unsigned OUTSTANDING_N    = 4,
  parameter int unsigned SIM_DELAY        = 1
) (
  input  logic        aclk,
  input  logic        aresetn,

  // LSU side
  input  logic [31:0] s_icb_cmd_addr,
  input  logic        s_icb_cmd_read,
  input  logic [31:0] s_icb_cmd_wdata,
  input  logic [3:0]  s_icb_cmd_wmask,
  input  logic        s_icb_cmd_valid,
  output logic        s_icb_cmd_ready,
  output logic [31:0] s_icb_rsp_rdata,
  output logic        s_icb_rsp_err,
  output logic        s_icb_rsp_valid,
  input  logic        s_icb_rsp_ready,

  // dcache side (cacheable)
  output logic [31:0] m0_icb_cmd_addr,
  output logic        m0_icb_cmd_read,
  output logic [31:0] m0_icb_cmd_wdata,
  output logic [3:0]  m0_icb_cmd_wmask,
  output logic        m0_icb_cmd_valid,
  input  logic        m0_icb_cmd_ready,
  input  logic [31:0] m0_icb_rsp_rdata,
  input  logic        m0_icb_rsp_err,
  input  logic        m0_icb_rsp_valid,
  output logic        m0_icb_rsp_ready,

  // peripheral bus side (uncacheable)
  output logic [31:0] m1_icb_cmd_addr,
  output logic        m1_icb_cmd_read,
  output logic [31:0] m1_icb_cmd_wdata,
  output logic [3:0]  m1_icb_cmd_wmask,
  output logic        m1_icb_cmd_valid,
  input  logic        m1_icb_cmd_ready,
  input  logic [31:0] m1_icb_rsp_rdata,
  input  logic        m1_icb_rsp_err,
  input  logic        m1_icb_rsp_valid,
  output logic        m1_icb_rsp_ready
);

  // Pointer width stays at least 1 bit so a depth-1 FIFO still elaborates.
  localparam int unsigned PTR_W = (OUTSTANDING_N > 32'd1) ? $clog2(OUTSTANDING_N) : 1;
  localparam int unsigned CNT_W = $clog2(OUTSTANDING_N + 32'd1);

  // Window end is formed in 33 bits so a window touching 2^32 does not wrap.
  localparam logic [32:0] WIN_LO = {1'b0, UNCACHEABLE_BASE};
  localparam logic [32:0] WIN_HI = {1'b0, UNCACHEABLE_BASE} + {1'b0, UNCACHEABLE_LEN};

  // Reject unsupported depths (and nonsensical delay values) at elaboration.
  if ((OUTSTANDING_N < 32'd1) || (OUTSTANDING_N > 32'd8) || (SIM_DELAY > 32'd1000)) begin : g_param_check
    $error("icb_dcache_router: OUTSTANDING_N must be 1..8");
  end

  // Tracking FIFO state: one target bit per outstanding command.
  logic [OUTSTANDING_N-1:0] r_tgt;
  logic [PTR_W-1:0]         r_wptr;
  logic [PTR_W-1:0]         r_rptr;
  logic [CNT_W-1:0]         r_cnt;

  logic w_sel;
  logic w_full;
  logic w_empty;
  logic w_head;
  logic w_push;
  logic w_pop;

  // Advance a FIFO pointer, wrapping explicitly so non-power-of-2 depths work.
  function automatic logic [PTR_W-1:0] f_ptr_inc(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] n;
    if (p == PTR_W'(OUTSTANDING_N - 32'd1)) begin
      n = '0;
    end else begin
      n = p + PTR_W'(1);
    end
    return n;
  endfunction

  // Address decode and FIFO status flags.
  always_comb begin
    w_sel   = 1'b0;
    w_full  = (r_cnt == CNT_W'(OUTSTANDING_N));
    w_empty = (r_cnt == CNT_W'(0));
    w_head  = r_tgt[r_rptr];
    if (({1'b0, s_icb_cmd_addr} >= WIN_LO) && ({1'b0, s_icb_cmd_addr} < WIN_HI)) begin
      w_sel = 1'b1;
    end else begin
      w_sel = 1'b0;
    end
  end

  // Command fields are broadcast; only the valid is steered.
  assign m0_icb_cmd_addr  = s_icb_cmd_addr;
  assign m0_icb_cmd_read  = s_icb_cmd_read;
  assign m0_icb_cmd_wdata = s_icb_cmd_wdata;
  assign m0_icb_cmd_wmask = s_icb_cmd_wmask;
  assign m1_icb_cmd_addr  = s_icb_cmd_addr;
  assign m1_icb_cmd_read  = s_icb_cmd_read;
  assign m1_icb_cmd_wdata = s_icb_cmd_wdata;
  assign m1_icb_cmd_wmask = s_icb_cmd_wmask;

  // Command steering: valid never looks at the downstream ready.
  always_comb begin
    m0_icb_cmd_valid = s_icb_cmd_valid & ~w_sel & ~w_full;
    m1_icb_cmd_valid = s_icb_cmd_valid &  w_sel & ~w_full;
    if (w_sel) begin
      s_icb_cmd_ready = ~w_full & m1_icb_cmd_ready;
    end else begin
      s_icb_cmd_ready = ~w_full & m0_icb_cmd_ready;
    end
  end

  // Response steering: only the target at the FIFO head may talk to the LSU.
  always_comb begin
    s_icb_rsp_valid  = 1'b0;
    s_icb_rsp_rdata  = 32'h0000_0000;
    s_icb_rsp_err    = 1'b0;
    m0_icb_rsp_ready = 1'b0;
    m1_icb_rsp_ready = 1'b0;
    if (w_empty) begin
      s_icb_rsp_valid  = 1'b0;
      s_icb_rsp_rdata  = 32'h0000_0000;
      s_icb_rsp_err    = 1'b0;
    end else if (w_head) begin
      s_icb_rsp_valid  = m1_icb_rsp_valid;
      s_icb_rsp_rdata  = m1_icb_rsp_rdata;
      s_icb_rsp_err    = m1_icb_rsp_err;
      m1_icb_rsp_ready = s_icb_rsp_ready;
    end else begin
      s_icb_rsp_valid  = m0_icb_rsp_valid;
      s_icb_rsp_rdata  = m0_icb_rsp_rdata;
      s_icb_rsp_err    = m0_icb_rsp_err;
      m0_icb_rsp_ready = s_icb_rsp_ready;
    end
  end

  assign w_push = s_icb_cmd_valid & s_icb_cmd_ready;
  assign w_pop  = s_icb_rsp_valid & s_icb_rsp_ready;

  // Record the target of each accepted command.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_tgt <= '0;
    end else if (w_push) begin
      r_tgt[r_wptr] <= w_sel;
    end else begin
      r_tgt <= r_tgt;
    end
  end

  // Write pointer advances on every accepted command.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wptr <= '0;
    end else if (w_push) begin
      r_wptr <= f_ptr_inc(r_wptr);
    end else begin
      r_wptr <= r_wptr;
    end
  end

  // Read pointer advances on every response delivered to the LSU.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rptr <= '0;
    end else if (w_pop) begin
      r_rptr <= f_ptr_inc(r_rptr);
    end else begin
      r_rptr <= r_rptr;
    end
  end

  // Outstanding count; simultaneous push and pop leaves it unchanged.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_cnt <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule
